e_run_sequencer: RTL and testbench
==================================

E_RUN_SEQUENCER -- requirements
Module: e_run_sequencer

Interface
REQ-001 Parameter MAX_DIGITS, default 150: digit buffer depth.
REQ-002 Parameter CONV_HOLD, default 2: number of cycles conv_start is held high.
REQ-003 Parameter TIMEOUT, default 50_000_000: watchdog limit in cycles, 1 s at 50 MHz.
REQ-004 CLOCK_50  in  1  clock; all logic is rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 go  in  1  run request; a single-cycle pulse is sufficient.
REQ-007 calc_start  out  1  start pulse to the e calculator.
REQ-008 calc_done  in  1  calculator finished; result stable.
REQ-009 conv_start  out  1  start to the binary-to-decimal converter.
REQ-010 conv_valid  in  1  conv_decimal is valid this cycle.
REQ-011 conv_decimal  in  4  one decimal digit, most significant digit first.
REQ-012 conv_done  in  1  converter finished.
REQ-013 rd_addr  in  8  display read address.
REQ-014 rd_data  out  4  buffered digit at the registered rd_addr.
REQ-015 digit_count  out  8  number of digits stored in this run.
REQ-016 busy  out  1  high in CALC_START, CALC_WAIT, CONV_START and CONV_RUN.
REQ-017 ready  out  1  high in READY only.
REQ-018 error  out  1  high in ERROR only.
REQ-019 ovf  out  1  sticky; set when a digit arrives with the buffer full.

Function
REQ-020 States SHALL be IDLE, CALC_START, CALC_WAIT, CONV_START, CONV_RUN, READY and ERROR.
REQ-021 IDLE, READY and ERROR SHALL go to CALC_START on go; these are the only states that accept go.
REQ-022 Entry to CALC_START SHALL clear digit_count, ovf and the watchdog counter in the same edge.
REQ-023 CALC_START SHALL assert calc_start for exactly one cycle and then go to CALC_WAIT.
REQ-024 CALC_WAIT SHALL go to CONV_START on calc_done.
REQ-025 CONV_START SHALL hold conv_start high for exactly CONV_HOLD consecutive cycles and then go to CONV_RUN with conv_start low.
REQ-026 In CONV_START and CONV_RUN, conv_valid SHALL write conv_decimal to buffer[digit_count] and increment digit_count when digit_count < MAX_DIGITS.
REQ-027 When conv_valid arrives with digit_count == MAX_DIGITS, the digit SHALL be discarded, ovf set and digit_count left unchanged.
REQ-028 CONV_RUN SHALL go to READY on conv_done.
REQ-029 If conv_valid and conv_done are high in the same cycle, the digit SHALL be stored and the state SHALL go to READY.
REQ-030 The watchdog SHALL count every cycle in CALC_WAIT, CONV_START and CONV_RUN, and reset to 0 on each state change.
REQ-031 When the watchdog reaches TIMEOUT-1 without the awaited event, the next state SHALL be ERROR.
REQ-032 If the awaited event and the watchdog limit occur in the same cycle, the event SHALL take priority.
REQ-033 conv_valid, conv_decimal, calc_done and conv_done SHALL be ignored in IDLE, READY and ERROR.
REQ-034 go SHALL be ignored while busy.
REQ-035 rd_data SHALL be registered with 1-cycle latency from rd_addr.
REQ-036 rd_data SHALL be 0 when rd_addr >= digit_count.
REQ-037 The buffer SHALL be writable only by the sequencer; rd_addr has no side effects.
REQ-038 Status outputs SHALL be registered, with no combinational path from any input.

Reset
REQ-039 On rst: state IDLE; calc_start, conv_start, busy, ready, error and ovf 0; digit_count 0; rd_data 0; watchdog 0.
REQ-040 Buffer contents SHALL not be reset; they are unreadable until rewritten (REQ-036).
REQ-041 rst asserted mid-run SHALL abort immediately, with no further calc_start or conv_start pulse after release.
REQ-042 After rst release, the block SHALL wait in IDLE for go.

Verification
REQ-043 Basic run: go; calc_done 10 cycles later; 5 conv_valid digits 2,7,1,8,2; then conv_done -> calc_start is one cycle, conv_start is high exactly 2 cycles, digit_count=5, ready=1, rd_addr=3 gives rd_data=8 one cycle later, rd_addr=5 gives 0.
REQ-044 Overflow: MAX_DIGITS=4, 6 digits delivered -> digit_count=4, ovf=1, buffer holds the first 4 digits.
REQ-045 Timeout: TIMEOUT=100, calc_done never asserted -> error=1 on the cycle after 100 cycles in CALC_WAIT; a later go restarts with digit_count=0 and error=0.
REQ-046 Same-cycle event: last conv_valid coincides with conv_done -> digit stored, count includes it, ready=1 on the next cycle.
REQ-047 Reset mid-run: rst asserted in CONV_RUN after 3 digits -> all outputs 0 next edge, no start pulses until go.
REQ-048 Busy go: go pulsed during CALC_WAIT -> no second calc_start; the run completes normally.

Source files
------------

// File: rtl/e_run_sequencer.sv
// e_run_sequencer: orchestrates one "compute e" run. It kicks the calculator,
// then the binary-to-decimal converter, captures the streamed decimal digits
// into a local buffer for the display, and guards every wait with a watchdog.
module e_run_sequencer #(
  parameter int MAX_DIGITS = 150,
  parameter int CONV_HOLD  = 2,
  parameter int TIMEOUT    = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       go,
  output logic       calc_start,
  input  logic       calc_done,
  output logic       conv_start,
  input  logic       conv_valid,
  input  logic [3:0] conv_decimal,
  input  logic       conv_done,
  input  logic [7:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [7:0] digit_count,
  output logic       busy,
  output logic       ready,
  output logic       error,
  output logic       ovf
);

  localparam int AW     = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int WD_MAX = (TIMEOUT > CONV_HOLD) ? TIMEOUT : CONV_HOLD;
  localparam int WDW    = $clog2(WD_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, CALC_START, CALC_WAIT, CONV_START, CONV_RUN, READY, ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             calc_start_q, conv_start_q, busy_q, ready_q, error_q;
  logic [3:0]       rd_data_q;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             wdog_limit;

  logic [3:0]       mem [MAX_DIGITS];

  assign wdog_limit = (wdog_q == WDW'(TIMEOUT - 1));
  assign wr_addr    = count_q[AW-1:0];

  // Next-state, digit capture and watchdog decisions.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wdog_d  = '0;

    case (state_q)
      IDLE, READY, ERROR: if (go) state_d = CALC_START;
      CALC_START:         state_d = CALC_WAIT;
      CALC_WAIT: begin
        if (calc_done)       state_d = CONV_START;
        else if (wdog_limit) state_d = ERROR;
      end
      CONV_START: begin
        // The watchdog doubles as the hold counter: it restarts on entry.
        if (wdog_q == WDW'(CONV_HOLD - 1)) state_d = CONV_RUN;
        else if (wdog_limit)               state_d = ERROR;
      end
      CONV_RUN: begin
        if (conv_done)       state_d = READY;
        else if (wdog_limit) state_d = ERROR;
      end
      default:            state_d = IDLE;
    endcase

    // Digits are accepted only while the converter is active.
    if ((state_q == CONV_START || state_q == CONV_RUN) && conv_valid) begin
      if (count_q < 8'(MAX_DIGITS)) begin
        wr_en   = 1'b1;
        count_d = count_q + 8'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // A new run starts with an empty buffer and a clean overflow flag.
    if (state_d == CALC_START) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end

    // Watchdog runs only in waiting states and restarts on any transition.
    if (state_d == state_q &&
        (state_q == CALC_WAIT || state_q == CONV_START || state_q == CONV_RUN))
      wdog_d = wdog_q + 1'b1;
  end

  // State, counters and registered status outputs.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      calc_start_q <= 1'b0;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      calc_start_q <= (state_d == CALC_START);
      conv_start_q <= (state_d == CONV_START);
      busy_q       <= (state_d == CALC_START) || (state_d == CALC_WAIT) ||
                      (state_d == CONV_START) || (state_d == CONV_RUN);
      ready_q      <= (state_d == READY);
      error_q      <= (state_d == ERROR);
    end
  end

  // Digit buffer write port.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: the buffer has no reset so it maps onto plain RAM; stale entries
    // are hidden by the digit_count guard on the read side.
    if (wr_en) mem[wr_addr] <= conv_decimal;
  end

  // Registered display read; addresses beyond the stored digits read as 0.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst)                    rd_data_q <= '0;
    else if (rd_addr < count_q) rd_data_q <= mem[rd_addr[AW-1:0]];
    else                        rd_data_q <= '0;
  end

  assign calc_start  = calc_start_q;
  assign conv_start  = conv_start_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign error       = error_q;
  assign ovf         = ovf_q;
  assign digit_count = count_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_e_run_sequencer.sv
// Directed bench for e_run_sequencer. Two instances share the stimulus:
// dut_a has a deep buffer, dut_b a 4-digit buffer for the overflow case.
// Both use a 100-cycle watchdog.
module tb_e_run_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       calc_done = 1'b0;
  logic       conv_valid = 1'b0;
  logic [3:0] conv_decimal = '0;
  logic       conv_done = 1'b0;
  logic [7:0] rd_addr = '0;

  logic       calc_start_a, conv_start_a, busy_a, ready_a, error_a, ovf_a;
  logic [3:0] rd_data_a;
  logic [7:0] count_a;
  logic       calc_start_b, conv_start_b, busy_b, ready_b, error_b, ovf_b;
  logic [3:0] rd_data_b;
  logic [7:0] count_b;

  int checks = 0;
  int errors = 0;
  int calc_cnt = 0;
  int conv_cnt = 0;

  e_run_sequencer #(.MAX_DIGITS(150), .CONV_HOLD(2), .TIMEOUT(100)) dut_a (
    .CLOCK_50(CLOCK_50), .rst(rst), .go(go),
    .calc_start(calc_start_a), .calc_done(calc_done),
    .conv_start(conv_start_a), .conv_valid(conv_valid),
    .conv_decimal(conv_decimal), .conv_done(conv_done),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .digit_count(count_a),
    .busy(busy_a), .ready(ready_a), .error(error_a), .ovf(ovf_a)
  );

  e_run_sequencer #(.MAX_DIGITS(4), .CONV_HOLD(2), .TIMEOUT(100)) dut_b (
    .CLOCK_50(CLOCK_50), .rst(rst), .go(go),
    .calc_start(calc_start_b), .calc_done(calc_done),
    .conv_start(conv_start_b), .conv_valid(conv_valid),
    .conv_decimal(conv_decimal), .conv_done(conv_done),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .digit_count(count_b),
    .busy(busy_b), .ready(ready_b), .error(error_b), .ovf(ovf_b)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Count cycles each start strobe is high on dut_a, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (calc_start_a) calc_cnt = calc_cnt + 1;
    if (conv_start_a) conv_cnt = conv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // go pulse; returns with the DUT in CALC_WAIT.
  task automatic start_run();
    go = 1'b1; tick(); go = 1'b0;
    tick();
  endtask

  // calc_done pulse; returns with the DUT in CONV_RUN (after the 2-cycle hold).
  task automatic finish_calc();
    calc_done = 1'b1; tick(); calc_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_digit(input logic [3:0] d, input logic done);
    conv_valid = 1'b1; conv_decimal = d; conv_done = done;
    tick();
    conv_valid = 1'b0; conv_done = 1'b0;
  endtask

  task automatic end_conv();
    conv_done = 1'b1; tick(); conv_done = 1'b0;
  endtask

  logic [3:0] basic_digits [5] = '{4'd2, 4'd7, 4'd1, 4'd8, 4'd2};
  logic [3:0] ovf_digits   [6] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy",       busy_a,       1'b0);
    check("rst_ready",      ready_a,      1'b0);
    check("rst_error",      error_a,      1'b0);
    check("rst_ovf",        ovf_a,        1'b0);
    check("rst_calc_start", calc_start_a, 1'b0);
    check("rst_conv_start", conv_start_a, 1'b0);
    check("rst_count",      count_a,      8'd0);
    check("rst_rd_data",    rd_data_a,    4'd0);
    rst = 1'b0;
    tick();

    // Basic run with a go pulse while busy
    calc_cnt = 0; conv_cnt = 0;
    go = 1'b1; tick(); go = 1'b0;
    check("basic_calc_start", calc_start_a, 1'b1);
    tick();
    check("basic_calc_start_one", calc_start_a, 1'b0);
    check("basic_busy", busy_a, 1'b1);
    repeat (3) tick();
    go = 1'b1; tick(); go = 1'b0;
    repeat (4) tick();
    finish_calc();
    for (int i = 0; i < 5; i++) send_digit(basic_digits[i], 1'b0);
    end_conv();
    check("basic_ready",      ready_a,  1'b1);
    check("basic_busy_done",  busy_a,   1'b0);
    check("basic_count",      count_a,  8'd5);
    check("basic_calc_pulses", calc_cnt, 1);
    check("basic_conv_cycles", conv_cnt, 2);
    rd_addr = 8'd3; tick();
    check("basic_rd3", rd_data_a, 4'd8);
    rd_addr = 8'd5; tick();
    check("basic_rd5", rd_data_a, 4'd0);
    rd_addr = 8'd0; tick();
    check("basic_rd0", rd_data_a, 4'd2);
    rd_addr = 8'd1;
    #1 check("basic_rd_latency", rd_data_a, 4'd2);
    tick();
    check("basic_rd1", rd_data_a, 4'd7);

    // Last digit coincides with conv_done
    start_run();
    finish_calc();
    send_digit(4'd3, 1'b0);
    send_digit(4'd1, 1'b0);
    send_digit(4'd4, 1'b1);
    check("same_ready", ready_a, 1'b1);
    check("same_count", count_a, 8'd3);
    rd_addr = 8'd2; tick();
    check("same_rd2", rd_data_a, 4'd4);
    rd_addr = 8'd3; tick();
    check("same_rd3", rd_data_a, 4'd0);

    // Overflow on the 4-digit instance
    start_run();
    finish_calc();
    for (int i = 0; i < 6; i++) send_digit(ovf_digits[i], 1'b0);
    end_conv();
    check("ovf_count_b", count_b, 8'd4);
    check("ovf_flag_b",  ovf_b,   1'b1);
    check("ovf_ready_b", ready_b, 1'b1);
    check("ovf_count_a", count_a, 8'd6);
    check("ovf_flag_a",  ovf_a,   1'b0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 8'(i); tick();
      check("ovf_rd_b", rd_data_b, ovf_digits[i]);
    end
    rd_addr = 8'd4; tick();
    check("ovf_rd4_b", rd_data_b, 4'd0);

    // Watchdog timeout in CALC_WAIT
    go = 1'b1; tick(); go = 1'b0;
    check("to_ovf_cleared",   ovf_b,   1'b0);
    check("to_count_cleared", count_b, 8'd0);
    tick();
    repeat (99) tick();
    check("to_error_early", error_a, 1'b0);
    check("to_busy_early",  busy_a,  1'b1);
    tick();
    check("to_error", error_a, 1'b1);
    check("to_busy",  busy_a,  1'b0);
    calc_done = 1'b1; tick(); calc_done = 1'b0;
    check("to_ignore_calc_done", error_a, 1'b1);
    go = 1'b1; tick(); go = 1'b0;
    check("to_restart_error", error_a,      1'b0);
    check("to_restart_calc",  calc_start_a, 1'b1);
    check("to_restart_count", count_a,      8'd0);

    // Reset in the middle of CONV_RUN
    tick();
    finish_calc();
    for (int i = 0; i < 3; i++) send_digit(4'd5, 1'b0);
    check("mid_count", count_a, 8'd3);
    rd_addr = 8'd0;
    calc_cnt = 0; conv_cnt = 0;
    rst = 1'b1; tick();
    check("mid_rst_busy",  busy_a,       1'b0);
    check("mid_rst_count", count_a,      8'd0);
    check("mid_rst_conv",  conv_start_a, 1'b0);
    check("mid_rst_rd",    rd_data_a,    4'd0);
    rst = 1'b0;
    calc_done = 1'b1; conv_valid = 1'b1; conv_done = 1'b1; tick();
    calc_done = 1'b0; conv_valid = 1'b0; conv_done = 1'b0;
    repeat (20) tick();
    check("mid_no_calc_pulse", calc_cnt, 0);
    check("mid_no_conv_pulse", conv_cnt, 0);
    check("mid_idle_busy",     busy_a,   1'b0);
    check("mid_idle_ready",    ready_a,  1'b0);
    check("mid_idle_count",    count_a,  8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
